// File: rtl/program_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : program_loader_if
// Brief    : Byte-stream handshake, program-memory write port and load status
//            bundle shared by the boot loader and its host/memory side.
// Revision : 1.0 - initial release
// ============================================================================
interface program_loader_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        restart;
    logic [31:0] byte_address;
    logic        write_enable;
    logic [31:0] write_data;
    logic        cpu_hold;
    logic        load_done;
    logic        load_error;
    logic [15:0] words_loaded;

    modport master (
        input  rx_data, rx_valid, restart,
        output rx_ready, byte_address, write_enable, write_data,
               cpu_hold, load_done, load_error, words_loaded
    );

    modport slave (
        output rx_data, rx_valid, restart,
        input  rx_ready, byte_address, write_enable, write_data,
               cpu_hold, load_done, load_error, words_loaded
    );
endinterface
`default_nettype wire

// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
// Module   : program_loader
// Brief    : Boot-time instruction RAM writer. Frame = LEN_LO, LEN_HI, 4*N
//            little-endian data bytes; optional trailing XOR check byte when
//            LOADER_CHECKSUM_EN is defined. Holds the core until loaded.
// Revision : 1.0 - initial release
// ============================================================================
module program_loader #(
    parameter int MEM_WORDS = 256
) (
    input  logic             clk,
    input  logic             reset,
    program_loader_if.master bus
);
    typedef enum logic [2:0] {
        S_LEN0  = 3'd0,
        S_LEN1  = 3'd1,
        S_LOAD  = 3'd2,
        S_CHK   = 3'd3,
        S_DONE  = 3'd4,
        S_ERROR = 3'd5
    } state_t;

    localparam logic [16:0] c_max_words = 17'(MEM_WORDS);
`ifdef LOADER_CHECKSUM_EN
    localparam state_t c_after_load = S_CHK;
`else
    localparam state_t c_after_load = S_DONE;
`endif

    state_t      state_q, state_d;
    logic [15:0] len_q, len_d;
    logic [23:0] part_q, part_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [15:0] words_loaded_q, words_loaded_d;
    logic [31:0] byte_address_q, byte_address_d;
    logic [31:0] write_data_q, write_data_d;
    logic        write_enable_q, write_enable_d;
    logic        rx_ready_q, rx_ready_d;
    logic        cpu_hold_q, cpu_hold_d;
    logic        load_done_q, load_done_d;
    logic        load_error_q, load_error_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  chk_q, chk_d;
`endif

    logic        w_xfer;
    logic [15:0] w_len_full;

    assign w_xfer     = bus.rx_valid & rx_ready_q;
    assign w_len_full = {bus.rx_data, len_q[7:0]};

    always_comb begin
        state_d        = state_q;
        len_d          = len_q;
        part_d         = part_q;
        byte_cnt_d     = byte_cnt_q;
        words_loaded_d = words_loaded_q;
        byte_address_d = byte_address_q;
        write_data_d   = write_data_q;
        write_enable_d = 1'b0;
`ifdef LOADER_CHECKSUM_EN
        chk_d          = chk_q;
`endif
        case (state_q)
            S_LEN0: begin
                if (w_xfer) begin
                    len_d[7:0] = bus.rx_data;
                    state_d    = S_LEN1;
                end
            end
            S_LEN1: begin
                if (w_xfer) begin
                    len_d[15:8] = bus.rx_data;
                    if (w_len_full == 16'd0)
                        state_d = c_after_load;
                    else if ({1'b0, w_len_full} > c_max_words)
                        state_d = S_ERROR;
                    else
                        state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (w_xfer) begin
                    part_d     = {bus.rx_data, part_q[23:8]};
                    byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                    chk_d      = chk_q ^ bus.rx_data;
`endif
                    // Fourth byte completes a word: strobe it out next cycle
                    // at the pre-increment index.
                    if (byte_cnt_q == 2'd3) begin
                        write_enable_d = 1'b1;
                        byte_address_d = {14'd0, words_loaded_q, 2'b00};
                        write_data_d   = {bus.rx_data, part_q};
                        words_loaded_d = words_loaded_q + 16'd1;
                        if (words_loaded_q == len_q - 16'd1)
                            state_d = c_after_load;
                    end
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHK: begin
                if (w_xfer)
                    state_d = (bus.rx_data == chk_q) ? S_DONE : S_ERROR;
            end
`endif
            S_DONE, S_ERROR: begin
                if (bus.restart) begin
                    state_d        = S_LEN0;
                    len_d          = 16'd0;
                    part_d         = 24'd0;
                    byte_cnt_d     = 2'd0;
                    words_loaded_d = 16'd0;
`ifdef LOADER_CHECKSUM_EN
                    chk_d          = 8'd0;
`endif
                end
            end
            default: state_d = S_ERROR;
        endcase

        // Status outputs decode the next state so they register alongside it.
        rx_ready_d   = (state_d != S_DONE) && (state_d != S_ERROR);
        cpu_hold_d   = (state_d != S_DONE);
        load_done_d  = (state_d == S_DONE);
        load_error_d = (state_d == S_ERROR);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_LEN0;
            len_q          <= 16'd0;
            part_q         <= 24'd0;
            byte_cnt_q     <= 2'd0;
            words_loaded_q <= 16'd0;
            byte_address_q <= 32'd0;
            write_data_q   <= 32'd0;
            write_enable_q <= 1'b0;
            rx_ready_q     <= 1'b1;
            cpu_hold_q     <= 1'b1;
            load_done_q    <= 1'b0;
            load_error_q   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            chk_q          <= 8'd0;
`endif
        end else begin
            state_q        <= state_d;
            len_q          <= len_d;
            part_q         <= part_d;
            byte_cnt_q     <= byte_cnt_d;
            words_loaded_q <= words_loaded_d;
            byte_address_q <= byte_address_d;
            write_data_q   <= write_data_d;
            write_enable_q <= write_enable_d;
            rx_ready_q     <= rx_ready_d;
            cpu_hold_q     <= cpu_hold_d;
            load_done_q    <= load_done_d;
            load_error_q   <= load_error_d;
`ifdef LOADER_CHECKSUM_EN
            chk_q          <= chk_d;
`endif
        end
    end

    assign bus.rx_ready     = rx_ready_q;
    assign bus.byte_address = byte_address_q;
    assign bus.write_enable = write_enable_q;
    assign bus.write_data   = write_data_q;
    assign bus.cpu_hold     = cpu_hold_q;
    assign bus.load_done    = load_done_q;
    assign bus.load_error   = load_error_q;
    assign bus.words_loaded = words_loaded_q;
endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_program_loader
// Brief    : Directed, table-driven self-checking bench for program_loader.
// Revision : 1.0 - initial release
// ============================================================================
module tb_program_loader;
    localparam int MEM_WORDS = 256;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    program_loader_if bus ();

    program_loader #(.MEM_WORDS(MEM_WORDS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [15:0] n;
        logic [31:0] w0;
        logic [31:0] w1;
        logic        gap;
        logic        exp_done;
        logic        exp_err;
        logic [31:0] exp_words;
    } vec_t;

    int total = 0;
    int bad   = 0;

    logic [31:0] cap_addr[$];
    logic [31:0] cap_data[$];

    always @(negedge clk) begin
        if (bus.write_enable === 1'b1) begin
            cap_addr.push_back(bus.byte_address);
            cap_data.push_back(bus.write_data);
        end
    end

    function automatic logic [31:0] gen_word(input logic [31:0] w0, input logic [31:0] w1,
                                             input int i);
        logic [31:0] iv;
        iv = 32'(i);
        if (i == 0) return w0;
        if (i == 1) return w1;
        return w0 ^ {iv[15:0], 16'hA5A5};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        bus.restart  = 1'b0;
        reset        = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int   waited;
        logic acc;
        waited       = 0;
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        forever begin
            acc = bus.rx_ready;
            @(posedge clk);
            #1;
            if (acc) break;
            waited++;
            if (waited > 50) begin
                total++;
                bad++;
                $display("FAIL send_byte timeout: byte %h ready=%b expected accept", b, bus.rx_ready);
                break;
            end
        end
        bus.rx_valid = 1'b0;
    endtask

    task automatic idle_if(input logic gap);
        if (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input vec_t v);
        logic [7:0]  chk;
        logic [31:0] w;
        chk = 8'h00;
        send_byte(v.n[7:0]);
        idle_if(v.gap);
        send_byte(v.n[15:8]);
        if (!v.exp_err) begin
            for (int i = 0; i < int'(v.n); i++) begin
                w = gen_word(v.w0, v.w1, i);
                for (int k = 0; k < 4; k++) begin
                    idle_if(v.gap);
                    send_byte(w[8*k +: 8]);
                    chk = chk ^ w[8*k +: 8];
                end
            end
`ifdef LOADER_CHECKSUM_EN
            idle_if(v.gap);
            send_byte(chk);
`endif
        end
    endtask

    task automatic check_result(input string tag, input vec_t v, input int base);
        int got;
        repeat (3) @(posedge clk);
        #1;
        got = cap_addr.size() - base;
        check($sformatf("%s nwrites", tag), 32'(got), v.exp_words);
        for (int i = 0; i < got && i < int'(v.exp_words); i++) begin
            check($sformatf("%s addr[%0d]", tag, i), cap_addr[base+i], 32'(i) * 32'd4);
            check($sformatf("%s data[%0d]", tag, i), cap_data[base+i], gen_word(v.w0, v.w1, i));
        end
        check($sformatf("%s load_done", tag),    32'(bus.load_done),    32'(v.exp_done));
        check($sformatf("%s load_error", tag),   32'(bus.load_error),   32'(v.exp_err));
        check($sformatf("%s cpu_hold", tag),     32'(bus.cpu_hold),     32'(!v.exp_done));
        check($sformatf("%s rx_ready", tag),     32'(bus.rx_ready),     32'd0);
        check($sformatf("%s words_loaded", tag), 32'(bus.words_loaded), v.exp_words);
    endtask

    task automatic pulse_restart();
        bus.restart = 1'b1;
        @(posedge clk);
        #1 bus.restart = 1'b0;
    endtask

    vec_t vecs[8];
    vec_t v;
    int   base;

    initial begin
        //           n         w0            w1            gap   done  err   words
        vecs[0] = '{16'd2,     32'h00000013, 32'h00100093, 1'b0, 1'b1, 1'b0, 32'd2};
        vecs[1] = '{16'd0,     32'h0,        32'h0,        1'b0, 1'b1, 1'b0, 32'd0};
        vecs[2] = '{16'd257,   32'h0,        32'h0,        1'b0, 1'b0, 1'b1, 32'd0};
        vecs[3] = '{16'd1,     32'h80000437, 32'h0,        1'b0, 1'b1, 1'b0, 32'd1};
        vecs[4] = '{16'd256,   32'hCAFE0001, 32'h5A5A5A5A, 1'b0, 1'b1, 1'b0, 32'd256};
        vecs[5] = '{16'hFFFF,  32'h0,        32'h0,        1'b0, 1'b0, 1'b1, 32'd0};
        vecs[6] = '{16'd3,     32'hDEADBEEF, 32'h12345678, 1'b1, 1'b1, 1'b0, 32'd3};
        vecs[7] = '{16'd2,     32'h00000013, 32'h00100093, 1'b1, 1'b1, 1'b0, 32'd2};

        do_reset();
        check("reset rx_ready",     32'(bus.rx_ready),     32'd1);
        check("reset cpu_hold",     32'(bus.cpu_hold),     32'd1);
        check("reset write_enable", 32'(bus.write_enable), 32'd0);
        check("reset byte_address", bus.byte_address,      32'd0);
        check("reset write_data",   bus.write_data,        32'd0);
        check("reset load_done",    32'(bus.load_done),    32'd0);
        check("reset load_error",   32'(bus.load_error),   32'd0);
        check("reset words_loaded", 32'(bus.words_loaded), 32'd0);

        for (int t = 0; t < 8; t++) begin
            do_reset();
            base = cap_addr.size();
            send_frame(vecs[t]);
            check_result($sformatf("vec%0d", t), vecs[t], base);
        end

        // Empty frame: completion visible right after LEN_HI is taken.
        do_reset();
        send_byte(8'h00);
        send_byte(8'h00);
`ifdef LOADER_CHECKSUM_EN
        check("n0 rx_ready in chk", 32'(bus.rx_ready), 32'd1);
        send_byte(8'h00);
`endif
        check("n0 immediate done", 32'(bus.load_done), 32'd1);

        // Reset mid-word: partial word dropped, fresh frame loads cleanly.
        do_reset();
        base = cap_addr.size();
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'hAA);
        send_byte(8'hBB);
        do_reset();
        repeat (2) @(posedge clk);
        #1;
        check("midreset no write",     32'(cap_addr.size() - base), 32'd0);
        check("midreset rx_ready",     32'(bus.rx_ready),           32'd1);
        check("midreset words_loaded", 32'(bus.words_loaded),       32'd0);
        v = '{16'd1, 32'h80000437, 32'h0, 1'b0, 1'b1, 1'b0, 32'd1};
        send_frame(v);
        check_result("after_midreset", v, base);

        // Restart from DONE re-arms; restart while loading is ignored.
        pulse_restart();
        check("restart load_done",    32'(bus.load_done),    32'd0);
        check("restart cpu_hold",     32'(bus.cpu_hold),     32'd1);
        check("restart rx_ready",     32'(bus.rx_ready),     32'd1);
        check("restart words_loaded", 32'(bus.words_loaded), 32'd0);
        base = cap_addr.size();
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h44);
        send_byte(8'h33);
        pulse_restart();
        send_byte(8'h22);
        send_byte(8'h11);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h44 ^ 8'h33 ^ 8'h22 ^ 8'h11);
`endif
        v = '{16'd1, 32'h11223344, 32'h0, 1'b0, 1'b1, 1'b0, 32'd1};
        check_result("restart_ignored", v, base);

        // Restart from ERROR.
        do_reset();
        send_byte(8'h01);
        send_byte(8'h01);
        check("err load_error", 32'(bus.load_error), 32'd1);
        pulse_restart();
        check("err restart load_error", 32'(bus.load_error), 32'd0);
        check("err restart rx_ready",   32'(bus.rx_ready),   32'd1);

`ifdef LOADER_CHECKSUM_EN
        // Bad check byte: both words still written, core held, restart clears count.
        do_reset();
        base = cap_addr.size();
        v = vecs[0];
        v.exp_done = 1'b0;
        v.exp_err  = 1'b1;
        send_byte(8'h02);
        send_byte(8'h00);
        for (int i = 0; i < 2; i++)
            for (int k = 0; k < 4; k++)
                send_byte(gen_word(v.w0, v.w1, i) >> (8 * k));
        send_byte(8'h00);
        check_result("chk_mismatch", v, base);
        pulse_restart();
        check("chk restart words_loaded", 32'(bus.words_loaded), 32'd0);
        check("chk restart rx_ready",     32'(bus.rx_ready),     32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
